fp_result_normalizer: RTL



---
 rtl/fp_result_normalizer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_result_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : fp_result_normalizer
// Description : Normalize / round-to-nearest-even / pack back end of the
//               single-precision FP adder.  Four register ranks (input
//               capture, normalize, round, packed output) under a global
//               stall driven by the output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_result_normalizer #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_W-1:0]     in_exp,
    input  logic [FRAC_W+4:0]    in_mag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [3:0]           out_flags
);

    localparam int MAG_W = FRAC_W + 5;
    localparam int LZC_W = $clog2(MAG_W);
    localparam int XE_W  = EXP_W + 1;
    localparam logic [XE_W-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    // Whole pipeline moves together; it freezes only when a result waits.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !reset;

    // ---------------- stage 1: input capture ----------------
    logic                 r_s1_valid;
    logic                 r_s1_sign;
    logic [EXP_W-1:0]     r_s1_exp;
    logic [MAG_W-1:0]     r_s1_mag;

    // Capture the raw adder beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_mag   <= '0;
        end else if (advance) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= in_sign;
            r_s1_exp   <= in_exp;
            r_s1_mag   <= in_mag;
        end
    end

    // ---------------- stage 2: detect + normalize ----------------
    logic                 w_carry;
    logic                 w_is_zero;
    logic                 w_underflow;
    logic [LZC_W-1:0]     w_lzc;
    logic [MAG_W-2:0]     w_norm;
    logic [XE_W-1:0]      w_norm_exp;

    assign w_carry     = r_s1_mag[MAG_W-1];
    assign w_is_zero   = (r_s1_mag == '0);
    assign w_underflow = !w_carry && !w_is_zero &&
                         (XE_W'(r_s1_exp) <= XE_W'(w_lzc));

    // Leading-zero count of the hidden-bit-and-below field; highest set bit wins.
    always_comb begin
        w_lzc = '0;
        for (int i = 0; i < MAG_W - 1; i++) begin
            if (r_s1_mag[i]) w_lzc = LZC_W'(MAG_W - 2 - i);
        end
    end

    // Carry shifts right once folding the dropped bits into sticky; otherwise shift left by lzc.
    always_comb begin
        w_norm     = '0;
        w_norm_exp = '0;
        if (w_carry) begin
            w_norm     = {r_s1_mag[MAG_W-1:2], |r_s1_mag[1:0]};
            w_norm_exp = XE_W'(r_s1_exp) + XE_W'(1);
        end else begin
            w_norm     = r_s1_mag[MAG_W-2:0] << w_lzc;
            w_norm_exp = XE_W'(r_s1_exp) - XE_W'(w_lzc);
        end
    end

    logic                 r_s2_valid;
    logic                 r_s2_sign;
    logic [XE_W-1:0]      r_s2_exp;
    logic [MAG_W-2:0]     r_s2_norm;
    logic                 r_s2_zero;
    logic                 r_s2_uf;

    // Register the normalized vector and the special-case classification.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_norm  <= '0;
            r_s2_zero  <= 1'b0;
            r_s2_uf    <= 1'b0;
        end else if (advance) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_exp   <= w_norm_exp;
            r_s2_norm  <= w_norm;
            r_s2_zero  <= w_is_zero;
            r_s2_uf    <= w_underflow;
        end
    end

    // ---------------- stage 3: round to nearest even ----------------
    logic [FRAC_W:0]      w_mant;
    logic                 w_g;
    logic                 w_r;
    logic                 w_s;
    logic                 w_round_up;
    logic [FRAC_W+1:0]    w_sum;
    logic [FRAC_W-1:0]    w_frac_rnd;
    logic [XE_W-1:0]      w_exp_rnd;

    assign w_mant     = r_s2_norm[MAG_W-2:3];
    assign w_g        = r_s2_norm[2];
    assign w_r        = r_s2_norm[1];
    assign w_s        = r_s2_norm[0];
    assign w_round_up = w_g && (w_r || w_s || w_mant[0]);
    assign w_sum      = {1'b0, w_mant} + (FRAC_W+2)'(w_round_up);

    // A carry out of the mantissa leaves 1.000..0, so only the exponent moves.
    always_comb begin
        w_frac_rnd = w_sum[FRAC_W-1:0];
        w_exp_rnd  = r_s2_exp;
        if (w_sum[FRAC_W+1]) begin
            w_frac_rnd = '0;
            w_exp_rnd  = r_s2_exp + XE_W'(1);
        end
    end

    logic                 r_s3_valid;
    logic                 r_s3_sign;
    logic [XE_W-1:0]      r_s3_exp;
    logic [FRAC_W-1:0]    r_s3_frac;
    logic                 r_s3_inexact;
    logic                 r_s3_zero;
    logic                 r_s3_uf;

    // Register the rounded mantissa, final exponent and inexact status.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s3_valid   <= 1'b0;
            r_s3_sign    <= 1'b0;
            r_s3_exp     <= '0;
            r_s3_frac    <= '0;
            r_s3_inexact <= 1'b0;
            r_s3_zero    <= 1'b0;
            r_s3_uf      <= 1'b0;
        end else if (advance) begin
            r_s3_valid   <= r_s2_valid;
            r_s3_sign    <= r_s2_sign;
            r_s3_exp     <= w_exp_rnd;
            r_s3_frac    <= w_frac_rnd;
            r_s3_inexact <= w_g || w_r || w_s;
            r_s3_zero    <= r_s2_zero;
            r_s3_uf      <= r_s2_uf;
        end
    end

    // ---------------- stage 4: pack ----------------
    logic [31:0]          w_result;
    logic [3:0]           w_flags;

    // Zero beats underflow beats overflow beats the normal pack.
    always_comb begin
        w_result = {r_s3_sign, r_s3_exp[EXP_W-1:0], r_s3_frac};
        w_flags  = {1'b0, 1'b0, r_s3_inexact, 1'b0};
        if (r_s3_zero) begin
            w_result = '0;
            w_flags  = 4'b0001;
        end else if (r_s3_uf) begin
            w_result = {r_s3_sign, 31'b0};
            w_flags  = 4'b0110;
        end else if (r_s3_exp >= EXP_MAX) begin
            w_result = {r_s3_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            w_flags  = 4'b1010;
        end
    end

    // Output register; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (advance) begin
            out_valid  <= r_s3_valid;
            out_result <= w_result;
            out_flags  <= w_flags;
        end
    end

endmodule
`default_nettype wire
